// File: rtl/lane_deskew_if.sv
// Bundle between the training stage, the lane deskew/sync block and the frame buffer side.
// Streams carry no backpressure: a word moves on every cycle its valid/strobe is high.
interface lane_deskew_if #(
  parameter int LVDS_PAIRS = 8
);
  logic                      training_done;
  logic                      training_result;
  logic [LVDS_PAIRS*12-1:0]  data_par_trained;
  logic [LVDS_PAIRS-1:0]     data_valid;
  logic [LVDS_PAIRS*12-1:0]  pix_data;
  logic                      pix_valid;
  logic                      frame_start;
  logic                      line_start;
  logic                      lane_lock;
  logic [2:0]                sync_err;
  logic [1:0]                dbg_state;   // {armed, fsm state}

  modport master (
    output training_done, training_result, data_par_trained, data_valid,
    input  pix_data, pix_valid, frame_start, line_start, lane_lock, sync_err, dbg_state
  );

  modport slave (
    input  training_done, training_result, data_par_trained, data_valid,
    output pix_data, pix_valid, frame_start, line_start, lane_lock, sync_err, dbg_state
  );
endinterface

// File: rtl/lane_deskew_sync.sv
// Per-lane deskew FIFOs plus lane-0 SOF/SOL decode producing a flagged, aligned pixel stream.
// Optional macro DESKEW_LANE_CHECK_EN: sync words must match on every lane.
module lane_deskew_sync #(
  parameter int          LVDS_PAIRS = 8,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [11:0] SOF_CODE   = 12'hFF0,
  parameter logic [11:0] SOL_CODE   = 12'hF00,
  parameter int          LINE_WORDS = 256
) (
  input  logic          clk_rxg,
  input  logic          rst_rx,
  lane_deskew_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(LINE_WORDS + 1);
  localparam int W  = LVDS_PAIRS * 12;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LINE_MAX = CW'(LINE_WORDS);

  typedef enum logic {ST_SEARCH = 1'b0, ST_ACTIVE = 1'b1} state_e;

  logic [11:0]   mem_q [LVDS_PAIRS][FIFO_DEPTH];
  logic [11:0]   mem_d [LVDS_PAIRS][FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q [LVDS_PAIRS];
  logic [AW:0]   wr_ptr_d [LVDS_PAIRS];
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          armed_q, armed_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_fs_q, pend_fs_d;
  logic          pend_ls_q, pend_ls_d;
  logic          pix_valid_q, pix_valid_d;
  logic          frame_start_q, frame_start_d;
  logic          line_start_q, line_start_d;
  logic [W-1:0]  pix_data_q, pix_data_d;
  logic [2:0]    sync_err_q, sync_err_d;

  logic          arm, disarm, pop, overflow, flush, all_ne, any_full_wr, lane_bad;
  logic [LVDS_PAIRS-1:0] wr;
  logic [AW:0]   level [LVDS_PAIRS];
  logic [11:0]   head [LVDS_PAIRS];
  logic [W-1:0]  head_vec;
  logic [11:0]   w0;
  logic [2:0]    err_new;

  // FIFO bookkeeping: one shared read pointer since all lanes pop together.
  always_comb begin
    arm         = bus.training_done && bus.training_result;
    disarm      = bus.training_done && !bus.training_result;
    all_ne      = 1'b1;
    any_full_wr = 1'b0;
    head_vec    = '0;
    for (int i = 0; i < LVDS_PAIRS; i++) begin
      level[i] = wr_ptr_q[i] - rd_ptr_q;
      head[i]  = mem_q[i][rd_ptr_q[AW-1:0]];
      head_vec[i*12 +: 12] = head[i];
      wr[i]    = armed_q && !disarm && bus.data_valid[i];
      if (level[i] == '0) all_ne = 1'b0;
      if (wr[i] && (level[i] == FULL_LVL)) any_full_wr = 1'b1;
    end
    pop      = armed_q && !disarm && all_ne;
    overflow = any_full_wr && !pop;
    flush    = !armed_q || disarm || overflow;

    mem_d    = mem_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    for (int i = 0; i < LVDS_PAIRS; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      if (wr[i]) begin
        mem_d[i][wr_ptr_q[i][AW-1:0]] = bus.data_par_trained[i*12 +: 12];
        wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
      end
      if (flush) wr_ptr_d[i] = '0;
    end
    if (flush) rd_ptr_d = '0;
    armed_d = arm ? 1'b1 : (disarm ? 1'b0 : armed_q);
  end

  // Frame/line decode on the word being popped; outputs register at the pop edge.
  always_comb begin
    w0            = head[0];
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_fs_d     = pend_fs_q;
    pend_ls_d     = pend_ls_q;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    line_start_d  = 1'b0;
    pix_data_d    = pix_data_q;
    err_new       = 3'b000;
    lane_bad      = 1'b0;
`ifdef DESKEW_LANE_CHECK_EN
    if ((w0 == SOF_CODE) || (w0 == SOL_CODE)) begin
      for (int i = 1; i < LVDS_PAIRS; i++) begin
        if (head[i] != w0) lane_bad = 1'b1;
      end
    end
`endif
    if (pop) begin
      if (lane_bad) begin
        err_new[2] = 1'b1;
        state_d    = ST_SEARCH;
      end else begin
        unique case (state_q)
          ST_SEARCH: begin
            if (w0 == SOF_CODE) begin
              state_d   = ST_ACTIVE;
              cnt_d     = '0;
              pend_fs_d = 1'b1;
              pend_ls_d = 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (w0 == SOF_CODE) begin
              cnt_d     = '0;
              pend_fs_d = 1'b1;
              pend_ls_d = 1'b1;
            end else if (w0 == SOL_CODE) begin
              cnt_d     = '0;
              pend_ls_d = 1'b1;
            end else if (cnt_q < LINE_MAX) begin
              pix_valid_d   = 1'b1;
              frame_start_d = pend_fs_q;
              line_start_d  = pend_ls_q;
              pix_data_d    = head_vec;
              pend_fs_d     = 1'b0;
              pend_ls_d     = 1'b0;
              cnt_d         = cnt_q + CW'(1);
            end else begin
              err_new[1] = 1'b1;
              state_d    = ST_SEARCH;
            end
          end
          default: state_d = ST_SEARCH;
        endcase
      end
    end
    if (overflow) err_new[0] = 1'b1;
    if (flush) state_d = ST_SEARCH;
    sync_err_d = arm ? 3'b000 : (sync_err_q | err_new);
  end

  always_ff @(posedge clk_rxg) begin
    if (rst_rx) begin
      for (int i = 0; i < LVDS_PAIRS; i++) wr_ptr_q[i] <= '0;
      rd_ptr_q      <= '0;
      armed_q       <= 1'b0;
      state_q       <= ST_SEARCH;
      cnt_q         <= '0;
      pend_fs_q     <= 1'b0;
      pend_ls_q     <= 1'b0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      pix_data_q    <= '0;
      sync_err_q    <= 3'b000;
    end else begin
      for (int i = 0; i < LVDS_PAIRS; i++) wr_ptr_q[i] <= wr_ptr_d[i];
      rd_ptr_q      <= rd_ptr_d;
      armed_q       <= armed_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_fs_q     <= pend_fs_d;
      pend_ls_q     <= pend_ls_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      pix_data_q    <= pix_data_d;
      sync_err_q    <= sync_err_d;
    end
    mem_q <= mem_d;
  end

  assign bus.pix_data    = pix_data_q;
  assign bus.pix_valid   = pix_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.line_start  = line_start_q;
  assign bus.lane_lock   = (state_q == ST_ACTIVE);
  assign bus.sync_err    = sync_err_q;
  assign bus.dbg_state   = {armed_q, state_q};
endmodule

// File: tb/tb_lane_deskew_sync.sv
// Bench for lane_deskew_sync: directed and randomized skewed streams checked against
// a frame-level reference model with exact output timing.
module tb_lane_deskew_sync;
  localparam int NL = 8;
  localparam int LW = 4;
  localparam int W  = NL * 12;
  localparam int EW = W + 2 + 16;
  localparam logic [11:0] SOF = 12'hFF0;
  localparam logic [11:0] SOL = 12'hF00;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lane_deskew_if #(.LVDS_PAIRS(NL)) bus ();

  lane_deskew_sync #(
    .LVDS_PAIRS(NL), .FIFO_DEPTH(8), .SOF_CODE(SOF), .SOL_CODE(SOL), .LINE_WORDS(LW)
  ) dut (
    .clk_rxg (clk),
    .rst_rx  (rst),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // scoreboard: {cycle[15:0], frame_start, line_start, data}
  logic [EW-1:0] exp_q [$];
  logic [W-1:0]  vec_q [$];
  int            dly [NL];
  logic [W-1:0]  last_pix;

  // reference model state
  bit        m_active;
  int        m_cnt;
  bit        m_pfs, m_pls;
  logic [2:0] m_err;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] data_vec();
    logic [W-1:0] v;
    for (int i = 0; i < NL; i++) v[i*12 +: 12] = 12'($urandom_range(0, 12'hEFF));
    return v;
  endfunction

  function automatic logic [W-1:0] sync_vec(input logic [11:0] code);
    logic [W-1:0] v;
    for (int i = 0; i < NL; i++) v[i*12 +: 12] = code;
    return v;
  endfunction

  // Frame rules applied to one aligned word vector; emitted words go to the scoreboard.
  function automatic void model_word(input logic [W-1:0] v, input int t_out);
    logic [11:0] c0;
    bit mism;
    c0   = v[11:0];
    mism = 1'b0;
`ifdef DESKEW_LANE_CHECK_EN
    if (c0 == SOF || c0 == SOL)
      for (int i = 1; i < NL; i++) if (v[i*12 +: 12] != c0) mism = 1'b1;
`endif
    if (mism) begin
      m_err[2] = 1'b1;
      m_active = 1'b0;
    end else if (c0 == SOF) begin
      m_active = 1'b1; m_cnt = 0; m_pfs = 1'b1; m_pls = 1'b1;
    end else if (!m_active) begin
      // dropped while searching
    end else if (c0 == SOL) begin
      m_cnt = 0; m_pls = 1'b1;
    end else if (m_cnt < LW) begin
      exp_q.push_back({16'(t_out), m_pfs, m_pls, v});
      m_pfs = 1'b0; m_pls = 1'b0; m_cnt++;
    end else begin
      m_err[1] = 1'b1;
      m_active = 1'b0;
    end
  endfunction

  task automatic check_outputs(input int t);
    logic [EW-1:0] e;
    bit hit;
    hit = (exp_q.size() > 0) && (int'(exp_q[0][W+17:W+2]) == t);
    chk("pix_valid", W'(bus.pix_valid), W'(hit));
    if (hit) begin
      e = exp_q.pop_front();
      chk("pix_data", bus.pix_data, e[W-1:0]);
      chk("frame_start", W'(bus.frame_start), W'(e[W+1]));
      chk("line_start", W'(bus.line_start), W'(e[W]));
      last_pix = e[W-1:0];
    end else begin
      chk("flags_idle", W'({bus.frame_start, bus.line_start}), W'(0));
      chk("pix_hold", bus.pix_data, last_pix);
    end
  endtask

  // driver: lane i sends vector k during cycle k+dly[i]
  task automatic run_stream();
    int n, maxd, idx;
    n = vec_q.size();
    maxd = 0;
    for (int i = 0; i < NL; i++) if (dly[i] > maxd) maxd = dly[i];
    for (int k = 0; k < n; k++) model_word(vec_q[k], k + maxd + 2);
    for (int t = 0; t < n + maxd + 4; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NL; i++) begin
        idx = t - dly[i];
        if (idx >= 0 && idx < n) begin
          bus.data_valid[i] = 1'b1;
          bus.data_par_trained[i*12 +: 12] = vec_q[idx][i*12 +: 12];
        end else begin
          bus.data_valid[i] = 1'b0;
          bus.data_par_trained[i*12 +: 12] = 12'h000;
        end
      end
      @(negedge clk);
      check_outputs(t);
    end
    bus.data_valid = '0;
    chk("stream_leftover", W'(exp_q.size()), W'(0));
    exp_q.delete();
    vec_q.delete();
  endtask

  task automatic train(input bit result);
    @(posedge clk); #1;
    bus.training_done = 1'b1;
    bus.training_result = result;
    @(posedge clk); #1;
    bus.training_done = 1'b0;
    if (result) m_err = 3'b000;
    else m_active = 1'b0;
  endtask

  task automatic aligned();
    for (int i = 0; i < NL; i++) dly[i] = 0;
  endtask

  task automatic push_line(input int nd);
    for (int d = 0; d < nd; d++) vec_q.push_back(data_vec());
  endtask

  initial begin
    logic [W-1:0] v;
    int nlines;
    bus.training_done = 1'b0;
    bus.training_result = 1'b0;
    bus.data_par_trained = '0;
    bus.data_valid = '0;
    m_active = 1'b0; m_cnt = 0; m_pfs = 1'b0; m_pls = 1'b0; m_err = 3'b000;
    last_pix = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pix_valid", W'(bus.pix_valid), W'(0));
    chk("rst_flags", W'({bus.frame_start, bus.line_start}), W'(0));
    chk("rst_lane_lock", W'(bus.lane_lock), W'(0));
    chk("rst_sync_err", W'(bus.sync_err), W'(0));
    chk("rst_pix_data", bus.pix_data, W'(0));

    // aligned SOF, SOL, 001..004
    train(1'b1);
    vec_q.push_back(sync_vec(SOF));
    vec_q.push_back(sync_vec(SOL));
    for (int d = 1; d <= 4; d++) vec_q.push_back(sync_vec(12'(d)));
    aligned();
    run_stream();
    chk("t1_lane_lock", W'(bus.lane_lock), W'(1));
    chk("t1_sync_err", W'(bus.sync_err), W'(0));

    // same stream, lane 3 three cycles late
    vec_q.push_back(sync_vec(SOF));
    vec_q.push_back(sync_vec(SOL));
    for (int d = 1; d <= 4; d++) vec_q.push_back(sync_vec(12'(d)));
    aligned();
    dly[3] = 3;
    run_stream();
    chk("t2_sync_err", W'(bus.sync_err), W'(0));

    // randomized frames with random per-lane skew
    repeat (6) begin
      vec_q.push_back(sync_vec(SOF));
      nlines = $urandom_range(1, 3);
      for (int l = 0; l < nlines; l++) begin
        if (l > 0 || $urandom_range(0, 1) == 1) vec_q.push_back(sync_vec(SOL));
        push_line($urandom_range(1, LW));
      end
      for (int i = 0; i < NL; i++) dly[i] = $urandom_range(0, 3);
      run_stream();
      chk("rnd_sync_err", W'(bus.sync_err), W'(m_err));
      chk("rnd_lane_lock", W'(bus.lane_lock), W'(m_active));
    end

    // line longer than LINE_WORDS
    vec_q.push_back(sync_vec(SOF));
    push_line(LW + 1);
    for (int i = 0; i < NL; i++) dly[i] = $urandom_range(0, 2);
    run_stream();
    chk("long_sync_err", W'(bus.sync_err), W'(3'b010));
    chk("long_lane_lock", W'(bus.lane_lock), W'(0));

    // failed training pulse mid-line
    vec_q.push_back(sync_vec(SOF));
    vec_q.push_back(sync_vec(SOL));
    push_line(4);
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      bus.data_valid = (t < 6) ? '1 : '0;
      bus.data_par_trained = (t < 6) ? vec_q[t] : '0;
      bus.training_done = (t == 3);
      bus.training_result = 1'b0;
      @(negedge clk);
      chk("disarm_pix_valid", W'(bus.pix_valid), W'(0));
      if (t >= 2) chk("disarm_lane_lock", W'(bus.lane_lock), W'(t <= 3));
    end
    vec_q.delete();
    m_active = 1'b0;
    chk("disarm_sync_err_kept", W'(bus.sync_err), W'(3'b010));
    train(1'b1);
    @(negedge clk);
    chk("rearm_sync_err", W'(bus.sync_err), W'(0));
    vec_q.push_back(sync_vec(SOF));
    push_line(3);
    aligned();
    run_stream();

    // lane 5 silent while the others overrun
    for (int t = 0; t < 9; t++) begin
      @(posedge clk); #1;
      bus.data_valid = '1;
      bus.data_valid[5] = 1'b0;
      bus.data_par_trained = data_vec();
      @(negedge clk);
      chk("ovf_pix_valid", W'(bus.pix_valid), W'(0));
    end
    @(posedge clk); #1;
    bus.data_valid = '0;
    m_err[0] = 1'b1;
    m_active = 1'b0;
    @(negedge clk);
    chk("ovf_sync_err", W'(bus.sync_err), W'(3'b001));
    chk("ovf_lane_lock", W'(bus.lane_lock), W'(0));
    // FIFOs must be empty: an aligned stream keeps exact timing
    vec_q.push_back(sync_vec(SOF));
    push_line(2);
    aligned();
    run_stream();
    chk("ovf_after_err", W'(bus.sync_err), W'(m_err));

    // SOF on lane 0 with a mismatching lane 2
    train(1'b1);
    v = sync_vec(SOF);
    v[2*12 +: 12] = 12'h000;
    vec_q.push_back(v);
    push_line(2);
    aligned();
    run_stream();
`ifdef DESKEW_LANE_CHECK_EN
    chk("lchk_sync_err", W'(bus.sync_err), W'(3'b100));
    chk("lchk_lane_lock", W'(bus.lane_lock), W'(0));
`else
    chk("lchk_sync_err", W'(bus.sync_err), W'(3'b000));
    chk("lchk_lane_lock", W'(bus.lane_lock), W'(1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
